muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit and its controlling FSM, sitting beside the EX-stage ALU.
- The main decoder routes OP-type instructions with funct7 = 0000001 here instead of to the ALU.
- Holds the pipeline via `stall` while iterating, then presents a 1-cycle `done` with `result` so the instruction advances to MEM.
- Radix-2: one product/quotient bit per cycle.

Parameters:
- XLEN, 32, operand/result width; the counter is clog2(XLEN) bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds a valid M-instruction; sampled only in IDLE.
- flush  in  1  EX-stage flush from the hazard unit; aborts the operation.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (forwarded).
- op_b  in  XLEN  rs2 value (forwarded).
- stall  out  1  freeze IF/ID/EX.
- done  out  1  result valid this cycle.
- result  out  XLEN  final value; held stable until the next start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, done=0, result=0, all internal registers cleared. stall=0 while in reset.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - Latch funct3 and the operand sign flags.
  - Latch |op_a| and |op_b| for signed ops. MUL uses signed×signed; the low word is identical to unsigned. MULHSU takes abs of op_a only.
  - Clear the accumulator, set count=0.
  - Next state: DONE if a special case applies, else CALC.
  - stall=1 combinationally in this cycle.
- Special cases, resolved in IDLE with no iteration:
  - Divide by zero (op_b=0): DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=all-ones): DIV gives 0x80000000, REM gives 0.
- CALC, one iteration per cycle:
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract; quotient in the low half, partial remainder in the high half.
  - count increments each cycle. When count==XLEN-1, next state is DONE.
  - stall=1 throughout.
- Entering DONE: apply sign fixup and register result.
  - MULH/MULHSU: negate the 2·XLEN product if the signs differ.
  - DIV: negate the quotient if the signs differ.
  - REM: the remainder takes the dividend's sign.
  - MUL returns the low word; MULH* return the high word.
- DONE: done=1, stall=0, next state IDLE unconditionally.
- start in DONE or CALC is ignored. A back-to-back M-op is accepted in the IDLE cycle that follows DONE.
- Latency with start sampled at edge E0 (cycle 0):
  - Normal: stall high in cycles 0..XLEN; done in cycle XLEN+1 (33).
  - Special case: stall high in cycle 0 only; done in cycle 1.
- flush=1 in any state: next state IDLE, done stays 0, result unchanged, stall=0 in that cycle.
  - start and flush together in IDLE: flush wins, nothing is latched.
- Reset mid-CALC: immediate return to IDLE, no done.
- All arithmetic is unsigned on the magnitude registers; signs are applied only at the DONE transition.

Decomposition:
- Package muldiv_pkg:
  - funct3 encodings for the eight M-ops.
  - State encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
  - The M-extension funct7 constant (0000001), reused by the main decoder.
- Natural sub-module: muldiv_datapath, holding the accumulator, magnitude registers, add/sub and sign fixup.
- muldiv_sequencer keeps the FSM, counter, special-case detection and the stall/done outputs.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), start pulse at cycle 0 → stall cycles 0–32; done at cycle 33; result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU same operands → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 0x12345678/0 → done at cycle 1, result=0xFFFFFFFF. REM 0x12345678/0 → 0x12345678. DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1. REM of the same operands → 0.
- flush asserted at cycle 10 of a DIV → IDLE at cycle 11, no done, stall low. A following MUL 3×4 completes with result=12.
- rst_n low at cycle 15 of a MUL → stall/done drop immediately, result=0. start while in CALC is ignored, and the original op's result is unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Imported by the sequencer, its datapath and the main decoder.
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] FUNCT7_M  = 7'b0000001;

   function automatic logic is_div(input logic [2:0] f);
      return f[2];
   endfunction

   function automatic logic signed_a(input logic [2:0] f);
      return (f != F3_MULHU) && (f != F3_DIVU) && (f != F3_REMU);
   endfunction

   function automatic logic signed_b(input logic [2:0] f);
      return (f == F3_MUL) || (f == F3_MULH) ||
             (f == F3_DIV) || (f == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage request/response bundle between the pipeline and the M-unit.
// The pipeline side is the master; the M-unit is the slave.
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic            flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, flush, funct3, op_a, op_b,
      input  stall, done, result
   );

   modport slave (
      input  start, flush, funct3, op_a, op_b,
      output stall, done, result
   );
endinterface

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add / restoring-divide datapath on operand magnitudes,
// with the sign fixup applied as the final value is registered.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic            finish,
   input  logic            special,
   input  logic [XLEN-1:0] special_val,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] result
);

   logic [2:0]        f3_q;
   logic              neg_a;
   logic              neg_b;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   mag_b;

   logic              na_in;
   logic              nb_in;
   logic [XLEN-1:0]   mag_a_in;
   logic [XLEN-1:0]   mag_b_in;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] acc_nx;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_val;

   always_comb begin
      na_in    = signed_a(funct3) & op_a[XLEN-1];
      nb_in    = signed_b(funct3) & op_b[XLEN-1];
      mag_a_in = na_in ? -op_a : op_a;
      mag_b_in = nb_in ? -op_b : op_b;
   end

   // Low half is multiplier / dividend; high half collects product / remainder.
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
              + {1'b0, (acc[0] ? mag_b : {XLEN{1'b0}})};
      rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff    = rem_sh - {1'b0, mag_b};
      acc_nx  = {mul_sum, acc[XLEN-1:1]};
      if (is_div(f3_q)) begin
         if (!diff[XLEN])
            acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            acc_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
   end

   always_comb begin
      prod    = (neg_a ^ neg_b) ? -acc_nx : acc_nx;
      quo     = acc_nx[XLEN-1:0];
      rem     = acc_nx[2*XLEN-1:XLEN];
      fix_val = prod[2*XLEN-1:XLEN];
      unique case (1'b1)
         (f3_q == F3_MUL): fix_val = prod[XLEN-1:0];
         (f3_q == F3_DIV): fix_val = (neg_a ^ neg_b) ? -quo : quo;
         (f3_q == F3_DIVU): fix_val = quo;
         (f3_q == F3_REM): fix_val = neg_a ? -rem : rem;
         (f3_q == F3_REMU): fix_val = rem;
         default: fix_val = prod[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f3_q   <= 3'b000;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         acc    <= '0;
         mag_b  <= '0;
         result <= '0;
      end else begin
         if (load) begin
            f3_q  <= funct3;
            neg_a <= na_in;
            neg_b <= nb_in;
            acc   <= {{XLEN{1'b0}}, mag_a_in};
            mag_b <= mag_b_in;
         end else if (step) begin
            acc <= acc_nx;
         end
         if (finish)
            result <= special ? special_val : fix_val;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Control FSM for the RV32M unit: stalls EX while iterating and
// resolves divide-by-zero and signed-overflow cases without iterating.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic      clk,
   input logic      rst_n,
   muldiv_if.slave  bus
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state;
   logic [CW-1:0]   count;
   logic            done_q;

   logic            accept;
   logic            last;
   logic            step;
   logic            finish;
   logic            div_zero;
   logic            ovf;
   logic            special;
   logic [XLEN-1:0] special_val;
   logic [XLEN-1:0] result;

   always_comb begin
      div_zero    = (bus.op_b == '0);
      ovf         = (bus.op_a == MIN_INT) && (bus.op_b == '1);
      special     = is_div(bus.funct3)
                  && (div_zero || (signed_b(bus.funct3) && ovf));
      special_val = bus.funct3[1] ? '0 : MIN_INT;
      if (div_zero)
         special_val = bus.funct3[1] ? bus.op_a : '1;
   end

   always_comb begin
      accept = rst_n && (state == IDLE) && bus.start && !bus.flush;
      step   = (state == CALC) && !bus.flush;
      last   = step && (count == CW'(XLEN - 1));
      finish = (accept && special) || last;
   end

   assign bus.stall  = accept || (rst_n && step);
   assign bus.done   = done_q;
   assign bus.result = result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state <= IDLE;
            count <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (bus.start) begin
                     count  <= '0;
                     state  <= special ? DONE : CALC;
                     done_q <= special;
                  end
               end
               CALC: begin
                  count <= count + CW'(1);
                  if (last) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   muldiv_datapath #(
      .XLEN (XLEN)
   ) u_dp (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (accept),
      .step        (step),
      .finish      (finish),
      .special     (special),
      .special_val (special_val),
      .funct3      (bus.funct3),
      .op_a        (bus.op_a),
      .op_b        (bus.op_b),
      .result      (result)
   );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and random checks of the RV32M sequencer against an
// arithmetic reference model.
module tb_muldiv_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [31:0] last_exp = 32'h0;

   always #5 clk = ~clk;

   muldiv_if #(.XLEN(32)) bus ();

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub, p;
      logic ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
      return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000
                                 && b == 32'hFFFF_FFFF));
   endfunction

   // Issue in IDLE (caller is #1 after an edge), wait for done, then
   // step one more cycle so the unit is back in IDLE.
   task automatic run_op(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input int poke);
      logic [31:0] exp;
      int lat;
      int gaps;
      bit seen;
      exp  = model(f, a, b);
      lat  = is_special(f, a, b) ? 1 : 33;
      gaps = 0;
      seen = 0;
      bus.start  = 1'b1;
      bus.funct3 = f;
      bus.op_a   = a;
      bus.op_b   = b;
      #1;
      chk({tag, " stall_c0"}, 32'(bus.stall), 32'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op_a  = $urandom;
      bus.op_b  = $urandom;
      for (int c = 1; c <= 40 && !seen; c++) begin
         if (c == poke) begin
            bus.start  = 1'b1;
            bus.funct3 = ~f;
            bus.op_a   = $urandom;
            bus.op_b   = 32'h0;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) begin
            seen = 1;
            chk({tag, " latency"}, 32'(c), 32'(lat));
            chk({tag, " result"}, bus.result, exp);
            chk({tag, " stall_done"}, 32'(bus.stall), 32'd0);
         end else begin
            if (bus.stall !== 1'b1) gaps++;
            @(posedge clk); #1;
         end
      end
      bus.start = 1'b0;
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " stall_gaps"}, 32'(gaps), 32'd0);
      @(posedge clk); #1;
      chk({tag, " done_drop"}, 32'(bus.done), 32'd0);
      chk({tag, " held"}, bus.result, exp);
      last_exp = exp;
   endtask

   initial begin
      int nd;
      logic [2:0] rf;
      logic [31:0] ra, rb;
      bus.start  = 1'b1;
      bus.flush  = 1'b0;
      bus.funct3 = 3'd0;
      bus.op_a   = 32'd5;
      bus.op_b   = 32'd6;

      // reset with start high: nothing may happen
      repeat (2) @(posedge clk);
      #1;
      chk("rst stall", 32'(bus.stall), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst result", bus.result, 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
      run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 7);
      run_op("divu_by0", 3'd5, 32'h1234_5678, 32'd0, 0);
      run_op("rem_by0", 3'd6, 32'h1234_5678, 32'd0, 0);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

      // flush in cycle 10 of a DIV
      bus.start  = 1'b1;
      bus.funct3 = 3'd4;
      bus.op_a   = 32'd1000;
      bus.op_b   = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      #1;
      chk("flush stall_c10", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      #1;
      chk("flush stall_c11", 32'(bus.stall), 32'd0);
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done !== 1'b0) nd++;
         @(posedge clk); #1;
      end
      chk("flush no_done", 32'(nd), 32'd0);
      chk("flush result", bus.result, last_exp);
      run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 0);

      // reset in cycle 15 of a MUL
      bus.start  = 1'b1;
      bus.funct3 = 3'd0;
      bus.op_a   = 32'h1234;
      bus.op_b   = 32'h5678;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst stall", 32'(bus.stall), 32'd0);
      chk("midrst done", 32'(bus.done), 32'd0);
      chk("midrst result", bus.result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (bus.done !== 1'b0 || bus.stall !== 1'b0) nd++;
      end
      chk("midrst quiet", 32'(nd), 32'd0);

      for (int i = 0; i < 24; i++) begin
         rf = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: ra = 32'hFFFF_FFFF;
            2: ra = 32'($urandom_range(0, 20));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
